// File: rtl/tlb_cmd_unit.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR between CP0 and the TLB array; 3-cycle IDLE->ISSUE->RESP.
// Owns the Random register; results are a one-cycle pulse with no backpressure.
module tlb_cmd_unit #(
  parameter int TLB_NUM = 16,
  localparam int IDX_W = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_type,
  input  logic [31:0]      entryhi_in,
  input  logic [31:0]      entrylo0_in,
  input  logic [31:0]      entrylo1_in,
  input  logic [31:0]      index_in,
  input  logic [IDX_W-1:0] wired_in,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random_out,
  output logic [18:0]      s1_vpn2,
  output logic             s1_odd_page,
  output logic [7:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic [18:0]      w_vpn2,
  output logic [7:0]       w_asid,
  output logic             w_g,
  output logic [19:0]      w_pfn0,
  output logic [2:0]       w_c0,
  output logic             w_d0,
  output logic             w_v0,
  output logic [19:0]      w_pfn1,
  output logic [2:0]       w_c1,
  output logic             w_d1,
  output logic             w_v1,
  output logic [IDX_W-1:0] r_index,
  input  logic [18:0]      r_vpn2,
  input  logic [7:0]       r_asid,
  input  logic             r_g,
  input  logic [19:0]      r_pfn0,
  input  logic [2:0]       r_c0,
  input  logic             r_d0,
  input  logic             r_v0,
  input  logic [19:0]      r_pfn1,
  input  logic [2:0]       r_c1,
  input  logic             r_d1,
  input  logic             r_v1,
  output logic             res_valid,
  output logic [3:0]       res_mask,
  output logic [31:0]      res_index,
  output logic [31:0]      res_entryhi,
  output logic [31:0]      res_entrylo0,
  output logic [31:0]      res_entrylo1
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_P  = 2'b00;
  localparam logic [1:0] OP_R  = 2'b01;
  localparam logic [1:0] OP_WR = 2'b11;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_NUM - 1);

  state_t     state;
  logic [1:0] op_q;

  logic unused_bits;
  assign unused_bits = ^{index_in[31:IDX_W], entryhi_in[12:8],
                         entrylo0_in[31:26], entrylo1_in[31:26]};

  // TLBP only ever probes with the even-page key.
  assign s1_odd_page = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_out <= IDX_MAX;
    end else if (wired_we || random_out == wired_in || random_out == '0) begin
      random_out <= IDX_MAX;
    end else begin
      random_out <= random_out - 1'b1;
    end
  end

  // Array-side outputs are loaded on acceptance so they are live only during ISSUE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      op_q         <= OP_P;
      op_ready     <= 1'b1;
      s1_vpn2      <= '0;
      s1_asid      <= '0;
      we           <= 1'b0;
      w_index      <= '0;
      w_vpn2       <= '0;
      w_asid       <= '0;
      w_g          <= 1'b0;
      w_pfn0       <= '0;
      w_c0         <= '0;
      w_d0         <= 1'b0;
      w_v0         <= 1'b0;
      w_pfn1       <= '0;
      w_c1         <= '0;
      w_d1         <= 1'b0;
      w_v1         <= 1'b0;
      r_index      <= '0;
      res_valid    <= 1'b0;
      res_mask     <= '0;
      res_index    <= '0;
      res_entryhi  <= '0;
      res_entrylo0 <= '0;
      res_entrylo1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            state    <= ISSUE;
            op_ready <= 1'b0;
            op_q     <= op_type;
            case (op_type)
              OP_P: begin
                s1_vpn2 <= entryhi_in[31:13];
                s1_asid <= entryhi_in[7:0];
              end
              OP_R: r_index <= index_in[IDX_W-1:0];
              default: begin
                we      <= 1'b1;
                w_index <= (op_type == OP_WR) ? random_out : index_in[IDX_W-1:0];
                w_vpn2  <= entryhi_in[31:13];
                w_asid  <= entryhi_in[7:0];
                w_g     <= entrylo0_in[0] & entrylo1_in[0];
                w_pfn0  <= entrylo0_in[25:6];
                w_c0    <= entrylo0_in[5:3];
                w_d0    <= entrylo0_in[2];
                w_v0    <= entrylo0_in[1];
                w_pfn1  <= entrylo1_in[25:6];
                w_c1    <= entrylo1_in[5:3];
                w_d1    <= entrylo1_in[2];
                w_v1    <= entrylo1_in[1];
              end
            endcase
          end
        end
        ISSUE: begin
          state     <= RESP;
          res_valid <= 1'b1;
          s1_vpn2   <= '0;
          s1_asid   <= '0;
          we        <= 1'b0;
          w_index   <= '0;
          w_vpn2    <= '0;
          w_asid    <= '0;
          w_g       <= 1'b0;
          w_pfn0    <= '0;
          w_c0      <= '0;
          w_d0      <= 1'b0;
          w_v0      <= 1'b0;
          w_pfn1    <= '0;
          w_c1      <= '0;
          w_d1      <= 1'b0;
          w_v1      <= 1'b0;
          r_index   <= '0;
          case (op_q)
            OP_P: begin
              res_mask  <= 4'b0001;
              res_index <= s1_found ? {{(32-IDX_W){1'b0}}, s1_index} : 32'h8000_0000;
            end
            OP_R: begin
              res_mask     <= 4'b1110;
              res_entryhi  <= {r_vpn2, 5'b0, r_asid};
              res_entrylo0 <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
              res_entrylo1 <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
            end
            default: res_mask <= 4'b0000;
          endcase
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          op_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_cmd_unit.sv
// Directed bench for tlb_cmd_unit with a small behavioural TLB array model.
module tb_tlb_cmd_unit;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic op_valid = 1'b0;
  logic op_ready;
  logic [1:0] op_type = 2'b00;
  logic [31:0] entryhi_in = '0, entrylo0_in = '0, entrylo1_in = '0, index_in = '0;
  logic [IDX_W-1:0] wired_in = '0;
  logic wired_we = 1'b0;
  logic [IDX_W-1:0] random_out;
  logic [18:0] s1_vpn2;
  logic s1_odd_page;
  logic [7:0] s1_asid;
  logic s1_found = 1'b0;
  logic [IDX_W-1:0] s1_index = '0;
  logic we;
  logic [IDX_W-1:0] w_index;
  logic [18:0] w_vpn2;
  logic [7:0] w_asid;
  logic w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0] w_c0, w_c1;
  logic w_d0, w_v0, w_d1, w_v1;
  logic [IDX_W-1:0] r_index;
  logic [18:0] r_vpn2;
  logic [7:0] r_asid;
  logic r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0] r_c0, r_c1;
  logic r_d0, r_v0, r_d1, r_v1;
  logic res_valid;
  logic [3:0] res_mask;
  logic [31:0] res_index, res_entryhi, res_entrylo0, res_entrylo1;

  int errors = 0;
  int checks = 0;

  // TLB array model: write on clock edge, combinational read.
  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [25:0] m_p0   [16];
  logic [25:0] m_p1   [16];

  initial for (int i = 0; i < 16; i++) begin
    m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_p0[i] = '0; m_p1[i] = '0;
  end

  always @(posedge clk) if (we) begin
    m_vpn2[w_index] <= w_vpn2;
    m_asid[w_index] <= w_asid;
    m_g[w_index]    <= w_g;
    m_p0[w_index]   <= {w_pfn0, w_c0, w_d0, w_v0};
    m_p1[w_index]   <= {w_pfn1, w_c1, w_d1, w_v1};
  end

  assign r_vpn2 = m_vpn2[r_index];
  assign r_asid = m_asid[r_index];
  assign r_g    = m_g[r_index];
  assign {r_pfn0, r_c0, r_d0, r_v0} = m_p0[r_index];
  assign {r_pfn1, r_c1, r_d1, r_v1} = m_p1[r_index];

  always #5 clk = ~clk;

  tlb_cmd_unit #(.TLB_NUM(16)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
    .index_in(index_in), .wired_in(wired_in), .wired_we(wired_we), .random_out(random_out),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .res_valid(res_valid), .res_mask(res_mask), .res_index(res_index),
    .res_entryhi(res_entryhi), .res_entrylo0(res_entrylo0), .res_entrylo1(res_entrylo1)
  );

  // Presents one op for the acceptance edge; returns at the ISSUE-cycle negedge.
  task automatic issue_op(input logic [1:0] t, input logic [31:0] eh, input logic [31:0] l0,
                          input logic [31:0] l1, input logic [31:0] idx);
    op_valid = 1'b1; op_type = t; entryhi_in = eh; entrylo0_in = l0; entrylo1_in = l1;
    index_in = idx;
    @(negedge clk);
    op_valid = 1'b0; entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0; index_in = '0;
  endtask

  task automatic test_reset;
    logic [IDX_W-1:0] exp_r;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_mask !== 4'b0000) begin errors++; $display("FAIL reset_res_mask got=%b exp=0000", res_mask); end
    checks++; if (res_index !== 32'h0) begin errors++; $display("FAIL reset_res_index got=%h exp=0", res_index); end
    resetn = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      exp_r = (i <= 15) ? 4'(15 - i) : 4'd15;
      checks++;
      if (random_out !== exp_r) begin
        errors++; $display("FAIL random_count step=%0d got=%0d exp=%0d", i, random_out, exp_r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tlbwi;
    issue_op(2'b10, 32'h1234_000A, 32'h0048_D15F, 32'h02AF_3792, 32'd5);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL wi_we got=%b exp=1", we); end
    checks++; if (w_index !== 4'd5) begin errors++; $display("FAIL wi_w_index got=%0d exp=5", w_index); end
    checks++; if (w_g !== 1'b0) begin errors++; $display("FAIL wi_w_g got=%b exp=0", w_g); end
    checks++; if (w_vpn2 !== 19'h091A0 || w_asid !== 8'h0A) begin
      errors++; $display("FAIL wi_tag got=%h/%h exp=091a0/0a", w_vpn2, w_asid); end
    checks++; if (w_pfn0 !== 20'h12345 || w_pfn1 !== 20'hABCDE) begin
      errors++; $display("FAIL wi_pfn got=%h/%h exp=12345/abcde", w_pfn0, w_pfn1); end
    checks++; if ({w_c0, w_d0, w_v0, w_c1, w_d1, w_v1} !== {3'd3, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL wi_flags got=%b", {w_c0, w_d0, w_v0, w_c1, w_d1, w_v1}); end
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL wi_busy got=%b exp=0", op_ready); end
    @(negedge clk);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL wi_we_pulse got=%b exp=0", we); end
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b0000) begin
      errors++; $display("FAIL wi_resp got=%b/%b exp=1/0000", res_valid, res_mask); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL wi_idle got=%b/%b exp=0/1", res_valid, op_ready); end
  endtask

  task automatic test_tlbr;
    issue_op(2'b01, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF5);
    checks++; if (r_index !== 4'd5) begin errors++; $display("FAIL r_index got=%0d exp=5", r_index); end
    @(negedge clk);
    checks++; if (r_index !== 4'd0) begin errors++; $display("FAIL r_index_idle got=%0d exp=0", r_index); end
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b1110) begin
      errors++; $display("FAIL r_resp got=%b/%b exp=1/1110", res_valid, res_mask); end
    checks++; if (res_entryhi !== 32'h1234_000A) begin
      errors++; $display("FAIL r_entryhi got=%h exp=1234000a", res_entryhi); end
    checks++; if (res_entrylo0 !== 32'h0048_D15E) begin
      errors++; $display("FAIL r_entrylo0 got=%h exp=0048d15e", res_entrylo0); end
    checks++; if (res_entrylo1 !== 32'h02AF_3792) begin
      errors++; $display("FAIL r_entrylo1 got=%h exp=02af3792", res_entrylo1); end
    @(negedge clk);
  endtask

  task automatic test_tlbp;
    s1_found = 1'b1; s1_index = 4'd5;
    issue_op(2'b00, 32'hABCD_E0_5C, 32'h0, 32'h0, 32'h0);
    checks++; if (s1_vpn2 !== 19'h55E6F || s1_asid !== 8'h5C || s1_odd_page !== 1'b0) begin
      errors++; $display("FAIL p_key got=%h/%h/%b exp=55e6f/5c/0", s1_vpn2, s1_asid, s1_odd_page); end
    @(negedge clk);
    s1_found = 1'b0; s1_index = 4'd0;
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b0001 || res_index !== 32'd5) begin
      errors++; $display("FAIL p_hit got=%b/%b/%h exp=1/0001/5", res_valid, res_mask, res_index); end
    checks++; if (res_entryhi !== 32'h1234_000A) begin
      errors++; $display("FAIL p_hold_entryhi got=%h exp=1234000a", res_entryhi); end
    @(negedge clk);
    s1_found = 1'b0; s1_index = 4'd9;
    issue_op(2'b00, 32'h0000_2001, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_index !== 32'h8000_0000) begin
      errors++; $display("FAIL p_miss got=%b/%h exp=1/80000000", res_valid, res_index); end
    @(negedge clk);
  endtask

  task automatic test_wired_tlbwr;
    bit seen;
    wired_in = 4'd4; wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    checks++; if (random_out !== 4'd15) begin errors++; $display("FAIL wired_load got=%0d exp=15", random_out); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (random_out !== 4'(15 - k)) begin
        errors++; $display("FAIL wired_count k=%0d got=%0d exp=%0d", k, random_out, 15 - k);
      end
    end
    @(negedge clk);
    checks++; if (random_out !== 4'd15) begin errors++; $display("FAIL wired_wrap got=%0d exp=15", random_out); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (random_out == 4'd7) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL wr_wait_random got=%0d exp=7", random_out);
    end else begin
      issue_op(2'b11, 32'h0000_4011, 32'h0000_0043, 32'h0000_0083, 32'd2);
      checks++; if (we !== 1'b1 || w_index !== 4'd7) begin
        errors++; $display("FAIL wr_index got=%b/%0d exp=1/7", we, w_index); end
      checks++; if (w_g !== 1'b1) begin errors++; $display("FAIL wr_w_g got=%b exp=1", w_g); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_mask !== 4'b0000) begin
        errors++; $display("FAIL wr_resp got=%b/%b exp=1/0000", res_valid, res_mask); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    s1_found = 1'b1; s1_index = 4'd3;
    op_valid = 1'b1; op_type = 2'b00; entryhi_in = 32'h0000_6001;
    @(negedge clk);
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL b2b_t1_ready got=%b exp=0", op_ready); end
    @(negedge clk);
    checks++; if (op_ready !== 1'b0 || res_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_t2 got=%b/%b exp=0/1", op_ready, res_valid); end
    @(negedge clk);
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_t3 got=%b/%b exp=1/0", op_ready, res_valid); end
    @(negedge clk);
    op_valid = 1'b0;
    checks++; if (op_ready !== 1'b0 || s1_vpn2 !== 19'h3) begin
      errors++; $display("FAIL b2b_second_accept got=%b/%h exp=0/3", op_ready, s1_vpn2); end
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_index !== 32'd3) begin
      errors++; $display("FAIL b2b_second_resp got=%b/%h exp=1/3", res_valid, res_index); end
    @(negedge clk);
    s1_found = 1'b0;
  endtask

  task automatic test_reset_in_issue;
    issue_op(2'b10, 32'hFFFF_E0FF, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'd9);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL rst_issue_we_pre got=%b exp=1", we); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_issue_we_async got=%b exp=0", we); end
    @(negedge clk);
    resetn = 1'b1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready got=%b exp=1", op_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res_valid !== 1'b0 || we !== 1'b0) begin
        errors++; $display("FAIL rst_issue_quiet cyc=%0d got=%b/%b exp=0/0", i, res_valid, we);
      end
      @(negedge clk);
    end
    checks++; if (m_vpn2[9] !== 19'h0 || m_p0[9] !== 26'h0) begin
      errors++; $display("FAIL rst_issue_no_write got=%h/%h exp=0/0", m_vpn2[9], m_p0[9]); end
  endtask

  initial begin
    test_reset;
    test_tlbwi;
    test_tlbr;
    test_tlbp;
    test_wired_tlbwr;
    test_back_to_back;
    test_reset_in_issue;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
